// File: rtl/quad_lo_pkg.sv
// Shared types and elaboration-time helpers for the quadrature LO generator.
// The QUAD_LO_DIR_EN macro (see quad_lo_gen) enables reverse rotation.
package quad_lo_pkg;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} lo_state_t;

    localparam int PHASES_MIN = 4;
    localparam int PHASES_MAX = 8;

    function automatic bit phases_legal(input int phases);
        return (phases == PHASES_MIN) || (phases == PHASES_MAX);
    endfunction

    // Full-scale amplitude of a signed sample of the given width.
    function automatic int lo_amp(input int out_w);
        return (1 << (out_w - 1)) - 1;
    endfunction

    // round(A * 0.70710678) in integer arithmetic, evaluated at elaboration.
    function automatic int lo_diag(input int out_w);
        longint a;
        a = longint'(lo_amp(out_w));
        return int'((a * 64'sd70710678 + 64'sd50000000) / 64'sd100000000);
    endfunction

endpackage

// File: rtl/quad_lo_rom.sv
// Combinational phase-index to (cos, sin) lookup for 4- or 8-step LO tables.
module quad_lo_rom
    import quad_lo_pkg::*;
#(
    parameter int OUT_W  = 2,
    parameter int PHASES = 4,
    parameter int IDX_W  = $clog2(PHASES)
) (
    input  logic        [IDX_W-1:0] idx,
    output logic signed [OUT_W-1:0] cos_v,
    output logic signed [OUT_W-1:0] sin_v
);

    localparam logic signed [OUT_W-1:0] AMP  = OUT_W'(lo_amp(OUT_W));
    localparam logic signed [OUT_W-1:0] DIAG = OUT_W'(lo_diag(OUT_W));

    always_comb begin
        cos_v = AMP;
        sin_v = '0;
        if (PHASES == PHASES_MAX) begin
            case (int'(idx))
                1: begin cos_v =  DIAG; sin_v =  DIAG; end
                2: begin cos_v =  '0;   sin_v =  AMP;  end
                3: begin cos_v = -DIAG; sin_v =  DIAG; end
                4: begin cos_v = -AMP;  sin_v =  '0;   end
                5: begin cos_v = -DIAG; sin_v = -DIAG; end
                6: begin cos_v =  '0;   sin_v = -AMP;  end
                7: begin cos_v =  DIAG; sin_v = -DIAG; end
                default: begin cos_v = AMP; sin_v = '0; end
            endcase
        end else begin
            case (int'(idx))
                1: begin cos_v =  '0;  sin_v =  AMP; end
                2: begin cos_v = -AMP; sin_v =  '0;  end
                3: begin cos_v =  '0;  sin_v = -AMP; end
                default: begin cos_v = AMP; sin_v = '0; end
            endcase
        end
    end

endmodule

// File: rtl/quad_lo_gen.sv
// Quadrature LO generator: steps a phase index every (dwell+1) enabled cycles.
// Define QUAD_LO_DIR_EN to add the dir port and decrementing rotation.
module quad_lo_gen
    import quad_lo_pkg::*;
#(
    parameter int OUT_W  = 2,
    parameter int CNT_W  = 8,
    parameter int PHASES = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          sync,
    input  logic        [CNT_W-1:0]       dwell,
`ifdef QUAD_LO_DIR_EN
    input  logic                          dir,
`endif
    output logic signed [OUT_W-1:0]       cos_out,
    output logic signed [OUT_W-1:0]       sin_out,
    output logic [$clog2(PHASES)-1:0]     phase_idx,
    output logic                          step_stb,
    output logic                          wrap_stb
);

    localparam int IDX_W = $clog2(PHASES);
    localparam logic signed [OUT_W-1:0] AMP = OUT_W'(lo_amp(OUT_W));

    lo_state_t                 state;
    logic        [CNT_W-1:0]   cnt;
    logic        [IDX_W-1:0]   nxt_idx;
    logic signed [OUT_W-1:0]   rom_cos;
    logic signed [OUT_W-1:0]   rom_sin;

    // Index the phase table with the upcoming index so outputs register with it.
    always_comb begin
`ifdef QUAD_LO_DIR_EN
        nxt_idx = dir ? (phase_idx - IDX_W'(1)) : (phase_idx + IDX_W'(1));
`else
        nxt_idx = phase_idx + IDX_W'(1);
`endif
    end

    quad_lo_rom #(
        .OUT_W  (OUT_W),
        .PHASES (PHASES),
        .IDX_W  (IDX_W)
    ) u_rom (
        .idx   (nxt_idx),
        .cos_v (rom_cos),
        .sin_v (rom_sin)
    );

    // Every enabled cycle counts, whether entering from IDLE, HOLD or staying in RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            phase_idx <= '0;
            cos_out   <= AMP;
            sin_out   <= '0;
            step_stb  <= 1'b0;
            wrap_stb  <= 1'b0;
        end else if (sync) begin
            state     <= IDLE;
            cnt       <= '0;
            phase_idx <= '0;
            cos_out   <= AMP;
            sin_out   <= '0;
            step_stb  <= 1'b0;
            wrap_stb  <= 1'b0;
        end else begin
            step_stb <= 1'b0;
            wrap_stb <= 1'b0;
            if (en) begin
                state <= RUN;
                // >= lets a lowered dwell force an immediate step.
                if (cnt >= dwell) begin
                    cnt       <= '0;
                    phase_idx <= nxt_idx;
                    cos_out   <= rom_cos;
                    sin_out   <= rom_sin;
                    step_stb  <= 1'b1;
                    wrap_stb  <= (nxt_idx == '0);
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else if (state == RUN) begin
                state <= HOLD;
            end
        end
    end

endmodule

// File: tb/tb_quad_lo_gen.sv
// Bench for quad_lo_gen: a default 4-phase instance and an 8-bit 8-phase instance share stimulus.
module tb_quad_lo_gen;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic              sync;
    logic [7:0]        dwell;
    logic              dir_q;
    logic signed [1:0] cos0, sin0;
    logic [1:0]        idx0;
    logic              step0, wrap0;
    logic signed [7:0] cos1, sin1;
    logic [2:0]        idx1;
    logic              step1, wrap1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    quad_lo_gen u_dut0 (
        .clk(clk), .reset(reset), .en(en), .sync(sync), .dwell(dwell),
`ifdef QUAD_LO_DIR_EN
        .dir(dir_q),
`endif
        .cos_out(cos0), .sin_out(sin0), .phase_idx(idx0),
        .step_stb(step0), .wrap_stb(wrap0)
    );

    quad_lo_gen #(.OUT_W(8), .CNT_W(8), .PHASES(8)) u_dut1 (
        .clk(clk), .reset(reset), .en(en), .sync(sync), .dwell(dwell),
`ifdef QUAD_LO_DIR_EN
        .dir(dir_q),
`endif
        .cos_out(cos1), .sin_out(sin1), .phase_idx(idx1),
        .step_stb(step1), .wrap_stb(wrap1)
    );

    // Reference model: phase advances after dwell+1 enabled cycles, values from trig.
    int m_cnt[2];
    int m_idx[2];
    bit m_stb[2];
    bit m_wrp[2];
    int m_w[2] = '{2, 8};
    int m_p[2] = '{4, 8};

    function automatic int ref_cs(input int w, input int p, input int k, input bit want_sin);
        real a, th, v;
        a  = (2.0 ** (w - 1)) - 1.0;
        th = 2.0 * 3.14159265358979 * k / p;
        v  = want_sin ? a * $sin(th) : a * $cos(th);
        return (v >= 0.0) ? int'($floor(v + 0.5)) : -int'($floor(-v + 0.5));
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 2; j++) begin
            m_cnt[j] = 0; m_idx[j] = 0; m_stb[j] = 0; m_wrp[j] = 0;
        end
    endtask

    task automatic model_edge();
        for (int j = 0; j < 2; j++) begin
            m_stb[j] = 0;
            m_wrp[j] = 0;
            if (reset || sync) begin
                m_cnt[j] = 0; m_idx[j] = 0;
            end else if (en) begin
                if (m_cnt[j] >= int'(dwell)) begin
                    m_cnt[j] = 0;
                    m_idx[j] = (m_idx[j] + (dir_q ? m_p[j] - 1 : 1)) % m_p[j];
                    m_stb[j] = 1;
                    m_wrp[j] = (m_idx[j] == 0);
                end else begin
                    m_cnt[j]++;
                end
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("m0_idx",  int'(idx0), m_idx[0]);
        chk("m0_cos",  int'(cos0), ref_cs(2, 4, m_idx[0], 0));
        chk("m0_sin",  int'(sin0), ref_cs(2, 4, m_idx[0], 1));
        chk("m0_step", int'(step0), int'(m_stb[0]));
        chk("m0_wrap", int'(wrap0), int'(m_wrp[0]));
        chk("m1_idx",  int'(idx1), m_idx[1]);
        chk("m1_cos",  int'(cos1), ref_cs(8, 8, m_idx[1], 0));
        chk("m1_sin",  int'(sin1), ref_cs(8, 8, m_idx[1], 1));
        chk("m1_step", int'(step1), int'(m_stb[1]));
        chk("m1_wrap", int'(wrap1), int'(m_wrp[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    // Asynchronous reset pulse between clock edges; outputs must react without a clock.
    task automatic pulse_reset();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("async_rst_cos1", int'(cos1), 127);
        chk("async_rst_sin1", int'(sin1), 0);
        check_model();
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        bit en;
        bit sync;
        int dwell;
        int idx;
        int c;
        int s;
        bit stb;
        bit wrp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int n_stb, n_wrp, first_stb, gap;
        int exp_c[8];
        int exp_s[8];

        vecs[0] = '{1, 0, 1, 0,  1,  0, 0, 0};
        vecs[1] = '{1, 0, 1, 1,  0,  1, 1, 0};
        vecs[2] = '{0, 0, 1, 1,  0,  1, 0, 0};
        vecs[3] = '{1, 0, 1, 1,  0,  1, 0, 0};
        vecs[4] = '{1, 0, 1, 2, -1,  0, 1, 0};
        vecs[5] = '{1, 0, 0, 3,  0, -1, 1, 0};
        vecs[6] = '{1, 0, 0, 0,  1,  0, 1, 1};
        vecs[7] = '{1, 1, 0, 0,  1,  0, 0, 0};
        vecs[8] = '{1, 0, 0, 1,  0,  1, 1, 0};
        vecs[9] = '{0, 1, 0, 0,  1,  0, 0, 0};
        exp_c = '{90, 0, -90, -127, -90, 0, 90, 127};
        exp_s = '{90, 127, 90, 0, -90, -127, -90, 0};

        reset = 1'b1; en = 1'b0; sync = 1'b0; dwell = 8'd0; dir_q = 1'b0;
        model_reset();
        #2;
        chk("reset_cos0", int'(cos0), 1);
        chk("reset_sin0", int'(sin0), 0);
        chk("reset_idx0", int'(idx0), 0);
        chk("reset_step0", int'(step0), 0);
        check_model();
        tick();
        reset = 1'b0;

        // Table of hand-computed vectors for the 4-phase instance.
        for (int i = 0; i < 10; i++) begin
            en = vecs[i].en; sync = vecs[i].sync; dwell = 8'(vecs[i].dwell);
            tick();
            chk($sformatf("vec%0d_idx", i),  int'(idx0),  vecs[i].idx);
            chk($sformatf("vec%0d_cos", i),  int'(cos0),  vecs[i].c);
            chk($sformatf("vec%0d_sin", i),  int'(sin0),  vecs[i].s);
            chk($sformatf("vec%0d_step", i), int'(step0), int'(vecs[i].stb));
            chk($sformatf("vec%0d_wrap", i), int'(wrap0), int'(vecs[i].wrp));
        end
        sync = 1'b0; en = 1'b0;

        // dwell=4 from reset: 5 cycles per phase, wrap every 20.
        pulse_reset();
        dwell = 8'd4; en = 1'b1;
        n_stb = 0; n_wrp = 0; first_stb = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (step0) begin
                n_stb++;
                if (first_stb == 0) first_stb = i;
            end
            if (wrap0) n_wrp++;
        end
        chk("d4_first_step", first_stb, 5);
        chk("d4_steps", n_stb, 8);
        chk("d4_wraps", n_wrp, 2);

        // dwell=0 on the 8-phase instance: one step per cycle.
        pulse_reset();
        dwell = 8'd0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("p8_cos%0d", i), int'(cos1), exp_c[i]);
            chk($sformatf("p8_sin%0d", i), int'(sin1), exp_s[i]);
            chk($sformatf("p8_wrap%0d", i), int'(wrap1), (i == 7) ? 1 : 0);
        end

        // Hold at count 3 for 7 cycles, then resume.
        pulse_reset();
        dwell = 8'd9;
        for (int i = 0; i < 10; i++) tick();
        chk("hold_pre_idx", int'(idx0), 1);
        for (int i = 0; i < 3; i++) tick();
        en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("hold_idx", int'(idx0), 1);
            chk("hold_sin", int'(sin0), 1);
        end
        en = 1'b1;
        gap = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (step0) break;
            gap++;
        end
        chk("hold_resume_gap", gap, 6);

        // Lowering dwell below the count forces a step.
        pulse_reset();
        dwell = 8'd20;
        for (int i = 0; i < 10; i++) tick();
        dwell = 8'd2;
        tick();
        chk("lower_dwell_step", int'(step0), 1);
        for (int r = 0; r < 2; r++) begin
            tick(); chk("lower_gap_a", int'(step0), 0);
            tick(); chk("lower_gap_b", int'(step0), 0);
            tick(); chk("lower_step", int'(step0), 1);
        end

        // sync overrides en in RUN.
        pulse_reset();
        dwell = 8'd0;
        tick(); tick();
        chk("pre_sync_idx", int'(idx0), 2);
        sync = 1'b1;
        tick();
        chk("sync_idx", int'(idx0), 0);
        chk("sync_cos", int'(cos0), 1);
        chk("sync_step", int'(step0), 0);
        sync = 1'b0;
        dwell = 8'd5;
        for (int i = 0; i < 9; i++) tick();
        chk("mid_dwell_idx", int'(idx0), 1);
        pulse_reset();
        chk("rst_mid_cos0", int'(cos0), 1);
        chk("rst_mid_idx0", int'(idx0), 0);

        // Rotation direction.
        dwell = 8'd0;
        tick();
        chk("dir_start_idx", int'(idx0), 1);
`ifdef QUAD_LO_DIR_EN
        dir_q = 1'b1;
        tick(); chk("dir_idx_a", int'(idx0), 0); chk("dir_wrap", int'(wrap0), 1);
        tick(); chk("dir_idx_b", int'(idx0), 3);
        tick(); chk("dir_idx_c", int'(idx0), 2);
        dir_q = 1'b0;
`else
        tick(); chk("inc_idx_a", int'(idx0), 2);
        tick(); chk("inc_idx_b", int'(idx0), 3);
        tick(); chk("inc_idx_c", int'(idx0), 0); chk("inc_wrap", int'(wrap0), 1);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) == 0) pulse_reset();
            en   = ($urandom_range(0, 99) < 85);
            sync = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 9) == 0) dwell = 8'($urandom_range(0, 4));
`ifdef QUAD_LO_DIR_EN
            if ($urandom_range(0, 7) == 0) dir_q = ~dir_q;
`endif
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
